// File: rtl/ram256_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ram256_arbiter
//  Purpose  : Shares one RAM256 macro (256 x 32, byte enables, synchronous
//             read) between a CPU data port (0) and a DMA/loader port (1).
//             Combinational grant, fixed one-cycle response pulse.
//  Revision : 1.0  initial release
// ============================================================================
module ram256_arbiter #(
  parameter int FIXED_PRIO = 0,  // 0: round-robin, 1: port 0 priority + starvation guard
  parameter int STARVE_MAX = 4   // forced port 1 win after this many losses (1..15)
) (
  input  logic        CLK,
  input  logic        RESETn,
  // port 0 (CPU data bus)
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [3:0]  p0_we,
  input  logic [7:0]  p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  // port 1 (DMA / loader)
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [3:0]  p1_we,
  input  logic [7:0]  p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  // RAM256 macro pins
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

  // Who owns the data coming out of the macro this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t     r_owner;
  logic       r_is_read;     // owner's access was a read (we == 0)
  logic       r_rr_last;     // 1: port 1 was granted most recently
  logic [3:0] r_starve_cnt;  // consecutive port 1 losses while it was requesting
  logic       w_grant0;
  logic       w_grant1;

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (RESETn) begin
      if (p0_valid && p1_valid) begin
        if (FIXED_PRIO != 0) begin
          if (r_starve_cnt == c_starve_max) w_grant1 = 1'b1;
          else                              w_grant0 = 1'b1;
        end else begin
          if (r_rr_last) w_grant0 = 1'b1;
          else           w_grant1 = 1'b1;
        end
      end else if (p0_valid) begin
        w_grant0 = 1'b1;
      end else if (p1_valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

  assign p0_ready = w_grant0;
  assign p1_ready = w_grant1;

  // Macro pin mux; address/data default to port 0 when idle.
  always_comb begin
    ram_en   = w_grant0 | w_grant1;
    ram_we   = 4'h0;
    ram_addr = p0_addr;
    ram_din  = p0_wdata;
    if (w_grant1) begin
      ram_we   = p1_we;
      ram_addr = p1_addr;
      ram_din  = p1_wdata;
    end else if (w_grant0) begin
      ram_we   = p0_we;
    end
  end

  // Round-robin history: remembers the last granted port.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_rr_last <= 1'b1;
    end else if (w_grant1) begin
      r_rr_last <= 1'b1;
    end else if (w_grant0) begin
      r_rr_last <= 1'b0;
    end
  end

  // Starvation counter: counts port 1 losses, saturating at the limit.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant1 || !p1_valid) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant0 && (r_starve_cnt < c_starve_max)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Response owner: the macro's read data appears one cycle after acceptance.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_owner   <= OWN_NONE;
      r_is_read <= 1'b0;
    end else if (w_grant0) begin
      r_owner   <= OWN_P0;
      r_is_read <= (p0_we == 4'h0);
    end else if (w_grant1) begin
      r_owner   <= OWN_P1;
      r_is_read <= (p1_we == 4'h0);
    end else begin
      r_owner   <= OWN_NONE;
      r_is_read <= 1'b0;
    end
  end

  // Response pulses; read data is a gated pass-through of Do0, zero otherwise.
  assign p0_rvalid = (r_owner == OWN_P0);
  assign p1_rvalid = (r_owner == OWN_P1);
  assign p0_rdata  = (p0_rvalid && r_is_read) ? ram_dout : 32'h0;
  assign p1_rdata  = (p1_rvalid && r_is_read) ? ram_dout : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ram256_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ram256_arbiter
//  Purpose  : Directed self-checking bench. dut_a is round-robin, dut_b is
//             fixed priority (STARVE_MAX=4); both share the same stimulus and
//             each drives its own behavioural RAM256 model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram256_arbiter;

  localparam logic [31:0] c_v1 = 32'hC0DE0001;  // initial content of addr 0x01
  localparam logic [31:0] c_v2 = 32'hC0DE0002;  // initial content of addr 0x02

  logic        clk;
  logic        rst_n;
  logic        p0_valid, p1_valid;
  logic [3:0]  p0_we, p1_we;
  logic [7:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;

  logic        a_p0_ready, a_p1_ready, a_p0_rvalid, a_p1_rvalid;
  logic [31:0] a_p0_rdata, a_p1_rdata;
  logic        a_ram_en;
  logic [3:0]  a_ram_we;
  logic [7:0]  a_ram_addr;
  logic [31:0] a_ram_din, a_dout;

  logic        b_p0_ready, b_p1_ready, b_p0_rvalid, b_p1_rvalid;
  logic [31:0] b_p0_rdata, b_p1_rdata;
  logic        b_ram_en;
  logic [3:0]  b_ram_we;
  logic [7:0]  b_ram_addr;
  logic [31:0] b_ram_din, b_dout;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  int tests;
  int fails;

  ram256_arbiter #(.FIXED_PRIO(0), .STARVE_MAX(4)) dut_a (
    .CLK(clk), .RESETn(rst_n),
    .p0_valid(p0_valid), .p0_ready(a_p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
    .p1_valid(p1_valid), .p1_ready(a_p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
    .ram_din(a_ram_din), .ram_dout(a_dout)
  );

  ram256_arbiter #(.FIXED_PRIO(1), .STARVE_MAX(4)) dut_b (
    .CLK(clk), .RESETn(rst_n),
    .p0_valid(p0_valid), .p0_ready(b_p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
    .p1_valid(p1_valid), .p1_ready(b_p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_din(b_ram_din), .ram_dout(b_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM256 for dut_a: byte writes, registered read.
  always @(posedge clk) begin
    if (a_ram_en) begin
      for (int b = 0; b < 4; b++)
        if (a_ram_we[b]) mem_a[a_ram_addr][8*b +: 8] <= a_ram_din[8*b +: 8];
      a_dout <= mem_a[a_ram_addr];
    end
  end

  // Behavioural RAM256 for dut_b.
  always @(posedge clk) begin
    if (b_ram_en) begin
      for (int b = 0; b < 4; b++)
        if (b_ram_we[b]) mem_b[b_ram_addr][8*b +: 8] <= b_ram_din[8*b +: 8];
      b_dout <= mem_b[b_ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [3:0] we0, input logic [7:0] ad0,
                       input logic [31:0] d0, input logic v1, input logic [3:0] we1,
                       input logic [7:0] ad1, input logic [31:0] d1);
    p0_valid = v0; p0_we = we0; p0_addr = ad0; p0_wdata = d0;
    p1_valid = v1; p1_we = we1; p1_addr = ad1; p1_wdata = d1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    a_dout = 32'h0;
    b_dout = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'hC0DE0000 | 32'(i);
      mem_b[i] = 32'hC0DE0000 | 32'(i);
    end

    // ---- reset state: request pending, but outputs forced idle ----
    rst_n = 1'b0;
    drive(1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    chk("rst_p0_ready", 32'(a_p0_ready), 32'd0);
    chk("rst_ram_en", 32'(a_ram_en), 32'd0);
    chk("rst_ram_we", 32'(a_ram_we), 32'd0);
    chk("rst_p0_rvalid", 32'(a_p0_rvalid), 32'd0);
    chk("rst_p1_rvalid", 32'(a_p1_rvalid), 32'd0);
    chk("rst_p0_rdata", a_p0_rdata, 32'h0);
    repeat (2) @(posedge clk);

    // ---- test 1: port 0 write then read of 0x10 ----
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t1_wr_ready", 32'(a_p0_ready), 32'd1);
    chk("t1_wr_ram_en", 32'(a_ram_en), 32'd1);
    chk("t1_wr_ram_we", 32'(a_ram_we), 32'hF);
    @(negedge clk);
    drive(1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    chk("t1_rd_ready", 32'(a_p0_ready), 32'd1);
    chk("t1_wr_rvalid", 32'(a_p0_rvalid), 32'd1);
    chk("t1_wr_rdata", a_p0_rdata, 32'h0);
    chk("t1_wr_p1_rvalid", 32'(a_p1_rvalid), 32'd0);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    chk("t1_rd_rvalid", 32'(a_p0_rvalid), 32'd1);
    chk("t1_rd_rdata", a_p0_rdata, 32'hDEADBEEF);
    chk("t1_rd_p1_rvalid", 32'(a_p1_rvalid), 32'd0);
    @(negedge clk);
    #1;
    chk("t1_idle_rvalid", 32'(a_p0_rvalid), 32'd0);
    chk("t1_idle_rdata", a_p0_rdata, 32'h0);

    // ---- tests 2+3: both ports continuously reading 0x01 / 0x02 ----
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rst_n = 1'b1;
        drive(1'b1, 4'h0, 8'h01, 32'h0, 1'b1, 4'h0, 8'h02, 32'h0);
      end else if (i == 10) begin
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0);
      end
      #1;
      if (i < 10) begin
        chk($sformatf("t2_p0_ready_%0d", i), 32'(a_p0_ready), 32'(i % 2 == 0));
        chk($sformatf("t2_p1_ready_%0d", i), 32'(a_p1_ready), 32'(i % 2 == 1));
        chk($sformatf("t3_p0_ready_%0d", i), 32'(b_p0_ready), 32'(i % 5 != 4));
        chk($sformatf("t3_p1_ready_%0d", i), 32'(b_p1_ready), 32'(i % 5 == 4));
      end
      if (i > 0) begin
        chk($sformatf("t2_p0_rvalid_%0d", i), 32'(a_p0_rvalid), 32'((i - 1) % 2 == 0));
        chk($sformatf("t2_p1_rvalid_%0d", i), 32'(a_p1_rvalid), 32'((i - 1) % 2 == 1));
        chk($sformatf("t2_p0_rdata_%0d", i), a_p0_rdata, ((i - 1) % 2 == 0) ? c_v1 : 32'h0);
        chk($sformatf("t2_p1_rdata_%0d", i), a_p1_rdata, ((i - 1) % 2 == 1) ? c_v2 : 32'h0);
        chk($sformatf("t3_p0_rvalid_%0d", i), 32'(b_p0_rvalid), 32'((i - 1) % 5 != 4));
        chk($sformatf("t3_p1_rdata_%0d", i), b_p1_rdata, ((i - 1) % 5 == 4) ? c_v2 : 32'h0);
      end
    end

    // ---- test 4: byte enables at the top address ----
    @(negedge clk);
    drive(1'b1, 4'hF, 8'hFF, 32'h11223344, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    chk("t4_p0_ready", 32'(a_p0_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 4'b0100, 8'hFF, 32'hAABBCCDD);
    #1;
    chk("t4_p1_wr_ready", 32'(a_p1_ready), 32'd1);
    chk("t4_p1_ram_we", 32'(a_ram_we), 32'h4);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 4'h0, 8'hFF, 32'h0);
    #1;
    chk("t4_wr_rvalid", 32'(a_p1_rvalid), 32'd1);
    chk("t4_wr_rdata", a_p1_rdata, 32'h0);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    chk("t4_rd_rvalid", 32'(a_p1_rvalid), 32'd1);
    chk("t4_rd_rdata", a_p1_rdata, 32'h11BB3344);
    chk("t4_rd_p0_rvalid", 32'(a_p0_rvalid), 32'd0);

    // ---- test 5: reset asserted after a read is accepted ----
    @(negedge clk);
    drive(1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    chk("t5_ready", 32'(a_p0_ready), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rvalid", 32'(a_p0_rvalid), 32'd0);
    chk("t5_rst_rdata", a_p0_rdata, 32'h0);
    chk("t5_rst_ram_en", 32'(a_ram_en), 32'd0);
    chk("t5_rst_ready", 32'(a_p0_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    chk("t5_rel_p0_rvalid", 32'(a_p0_rvalid), 32'd0);
    chk("t5_rel_p1_rvalid", 32'(a_p1_rvalid), 32'd0);
    @(negedge clk);
    drive(1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0);
    @(negedge clk);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    chk("t5_after_rvalid", 32'(a_p0_rvalid), 32'd1);
    chk("t5_after_rdata", a_p0_rdata, 32'hDEADBEEF);

    // ---- test 6: port 1 back-to-back reads of 0x00..0x07 ----
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 4'h0, 8'(i), 32'h0);
      else       drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0);
      #1;
      if (i < 8) chk($sformatf("t6_ready_%0d", i), 32'(a_p1_ready), 32'd1);
      if (i > 0) begin
        chk($sformatf("t6_rvalid_%0d", i), 32'(a_p1_rvalid), 32'd1);
        chk($sformatf("t6_rdata_%0d", i), a_p1_rdata, 32'hC0DE0000 | 32'(i - 1));
      end
    end
    @(negedge clk);
    #1;
    chk("t6_end_rvalid", 32'(a_p1_rvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram256_arbiter.md
Name: ram256_arbiter

Overview:
- Two-port arbiter that shares one RAM256 macro (256 x 32, byte write enables, synchronous read) between requester 0 (CPU data bus) and requester 1 (DMA/loader).
- Per-port valid/ready request channel and a fixed-latency response pulse.
- Drives the macro's EN0/WE0/A0/Di0 pins and routes Do0 back to the requester that issued the read.
- Sits between the bus fabric and the RAM256 instance; the macro's power pins are not touched.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 has priority, with a port 1 starvation guard.
- STARVE_MAX, 4: in FIXED_PRIO=1, the number of consecutive port 1 losses after which port 1 is forced to win once. Legal range 1..15.

Ports:
- CLK  in  1  Single clock, shared with the RAM256 CLK pin.
- RESETn  in  1  Asynchronous, active-low reset.
- p0_valid  in  1  Port 0 request valid.
- p0_ready  out  1  Port 0 request accepted this cycle.
- p0_we  in  4  Port 0 byte write enables; 0 means a read.
- p0_addr  in  8  Port 0 word address.
- p0_wdata  in  32  Port 0 write data.
- p0_rvalid  out  1  Port 0 response pulse.
- p0_rdata  out  32  Port 0 read data.
- p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_rvalid, p1_rdata: same as port 0, for port 1.
- ram_en  out  1  To EN0.
- ram_we  out  4  To WE0.
- ram_addr  out  8  To A0.
- ram_din  out  32  To Di0.
- ram_dout  in  32  From Do0.

Behaviour:
- Reset (RESETn=0, async):
  - rr_last=1, so port 0 wins the first tie.
  - starve_cnt=0, resp_owner=none.
  - p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0.
  - ram_en=0 and ram_we=0 are forced while RESETn=0.
  - p0_ready=p1_ready=0 while RESETn=0.
- Grant (combinational, same cycle):
  - grant0/grant1 are computed from p*_valid, at most one per cycle.
  - px_ready = grantx. Acceptance means px_valid & px_ready.
  - ready does not depend on a requester's own ready (no combinational loop).
- Arbitration when both ports are valid:
  - FIXED_PRIO=0: the port that was not granted most recently wins (rr_last). rr_last updates only on a grant.
  - FIXED_PRIO=1: port 0 wins, unless starve_cnt==STARVE_MAX, in which case port 1 wins.
- Starvation counter:
  - starve_cnt increments when p1_valid=1 and port 0 is granted.
  - It clears when port 1 is granted or when p1_valid=0.
  - It saturates at STARVE_MAX.
- Single valid port: that port is granted every cycle. Back-to-back accesses, one per cycle, are supported.
- Macro drive:
  - ram_en = grant0|grant1.
  - ram_we, ram_addr, ram_din are muxed from the granted port.
  - With no grant: ram_we=0, and ram_addr/ram_din hold the port 0 values (don't care).
- Response latency is exactly 1 cycle after acceptance:
  - On the next cycle px_rvalid=1 for exactly one cycle.
  - For a read (we==0), px_rdata = ram_dout. This is a combinational pass-through of Do0 gated by the registered owner/read flag.
  - For a write, px_rdata = 0.
  - When rvalid=0, rdata=0.
  - There is no response back-pressure; the requester must sink every pulse.
- Only one of p0_rvalid/p1_rvalid is high in any cycle.
- Read-after-write to the same address on consecutive cycles: the read returns the new data (macro write-before-read across cycles).
- Same-cycle requests from both ports to the same address: only the winner accesses; the loser retries. No merging.
- Requesters hold valid and payload stable until ready. A payload change while not ready is legal and simply re-arbitrated.
- Reset asserted mid-operation:
  - A pending response is dropped (rvalid not issued) and ram_en=0 immediately.
  - Memory contents are not cleared.

Test Plan:
1. Port 0 writes 0xDEADBEEF to addr 0x10 with we=0xF, then reads addr 0x10. Required: p0_ready=1 both cycles; the write response has p0_rvalid with rdata 0; the read response p0_rdata=0xDEADBEEF exactly one cycle after the read's acceptance; p1_rvalid=0 throughout.
2. FIXED_PRIO=0, both ports continuously valid reading 0x01 (port 0) and 0x02 (port 1). Required: grants alternate 0,1,0,1 starting with port 0; responses route to the correct port with that port's data.
3. FIXED_PRIO=1, STARVE_MAX=4, both ports continuously valid. Required: port 0 is granted 4 times, then port 1 once, repeating; starve_cnt never exceeds 4.
4. Byte enables: write 0x11223344 to addr 0xFF, then port 1 writes we=0b0100 with data 0xAABBCCDD, then reads 0xFF. Required: read data 0x11BB3344; address 0xFF operates with no wrap error.
5. Reset mid-read: accept a read, then assert RESETn=0 before the next edge. Required: no rvalid on either port, ram_en=0 asynchronously. After release, a read of a previously written address returns the stored value.
6. Port 1 alone issues 8 back-to-back reads of 0x00..0x07. Required: 8 consecutive p1_rvalid pulses, each with the matching data, and p1_ready=1 every cycle.
